// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The master drives requests and write data; the FIFO (slave) drives data and status.
interface param_sync_fifo_if #(
   parameter int DATA_WIDTH = 18,
   parameter int DEPTH      = 128
);
   logic                      w_en;
   logic [DATA_WIDTH-1:0]     data_in;
   logic                      r_en;
   logic [DATA_WIDTH-1:0]     data_out;
   logic                      full;
   logic                      empty;
   logic                      almost_full;
   logic                      almost_empty;
   logic [$clog2(DEPTH):0]    count;
   logic                      overflow;
   logic                      underflow;

   modport master (
      output w_en, data_in, r_en,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO using all DEPTH entries via a wrap bit, with count, level flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered (1-cycle latency).
module param_sync_fifo #(
   parameter int DATA_WIDTH = 18,
   parameter int DEPTH      = 128,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 4
) (
   input logic              clk,
   input logic              rst,
   param_sync_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $fatal(1, "param_sync_fifo: DEPTH must be a power of two >= 4");
      end
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
         $fatal(1, "param_sync_fifo: AF_LEVEL out of range 1..DEPTH");
      end
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
         $fatal(1, "param_sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
      end
   endgenerate

   logic [PW-1:0]         w_ptr, r_ptr, cnt;
   logic [PW-1:0]         w_ptr_nxt, r_ptr_nxt, cnt_nxt;
   logic                  full_r, empty_r, af_r, ae_r, ov_r, uf_r;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
   always_comb begin
      rd_acc    = bus.r_en & ~empty_r;
      wr_acc    = bus.w_en & (~full_r | rd_acc);
      w_ptr_nxt = w_ptr + {{AW{1'b0}}, wr_acc};
      r_ptr_nxt = r_ptr + {{AW{1'b0}}, rd_acc};
      cnt_nxt   = cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         cnt     <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         af_r    <= (AF_LEVEL == 0);
         ae_r    <= 1'b1;
         ov_r    <= 1'b0;
         uf_r    <= 1'b0;
      end else begin
         w_ptr   <= w_ptr_nxt;
         r_ptr   <= r_ptr_nxt;
         cnt     <= cnt_nxt;
         full_r  <= (w_ptr_nxt[AW] != r_ptr_nxt[AW]) && (w_ptr_nxt[AW-1:0] == r_ptr_nxt[AW-1:0]);
         empty_r <= (w_ptr_nxt == r_ptr_nxt);
         af_r    <= (cnt_nxt >= AF_L);
         ae_r    <= (cnt_nxt <= AE_L);
         ov_r    <= bus.w_en & ~wr_acc;
         uf_r    <= bus.r_en & ~rd_acc;
      end
   end

   // Storage is not reset; pointers alone define which words are valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[w_ptr[AW-1:0]] <= bus.data_in;
   end

`ifdef FIFO_FWFT_EN
   assign bus.data_out = empty_r ? '0 : mem[r_ptr[AW-1:0]];
`else
   logic [DATA_WIDTH-1:0] dout_r;

   // Read port samples mem before this edge's write lands, so full+simultaneous returns the oldest word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_r <= '0;
      else if (rd_acc) dout_r <= mem[r_ptr[AW-1:0]];
   end

   assign bus.data_out = dout_r;
`endif

   assign bus.full         = full_r;
   assign bus.empty        = empty_r;
   assign bus.almost_full  = af_r;
   assign bus.almost_empty = ae_r;
   assign bus.count        = cnt;
   assign bus.overflow     = ov_r;
   assign bus.underflow    = uf_r;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2): vector table plus
// hand sequences for pointer wrap, asynchronous reset and the first-word-fall-through build.
module tb_param_sync_fifo;
   localparam int DW = 18;
   localparam int DP = 8;

   typedef struct {
      logic          w, r;
      logic [DW-1:0] din;
      logic [DW-1:0] dout;
      logic [3:0]    cnt;
      logic          full, empty, af, ae, ov, uf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

   param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      bus.w_en    = w;
      bus.r_en    = r;
      bus.data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string nm, input int n);
      chk({nm, ".count"}, 32'(bus.count), 32'(n));
      chk({nm, ".full"},  32'(bus.full),  32'(n == DP));
      chk({nm, ".empty"}, 32'(bus.empty), 32'(n == 0));
      chk({nm, ".af"},    32'(bus.almost_full),  32'(n >= 6));
      chk({nm, ".ae"},    32'(bus.almost_empty), 32'(n <= 2));
   endtask

   function automatic vec_t mk(logic w, logic r, logic [DW-1:0] din, logic [DW-1:0] dout,
                               logic [3:0] c, logic f, logic e, logic af, logic ae,
                               logic ov, logic uf);
      vec_t v;
      v.w = w; v.r = r; v.din = din; v.dout = dout; v.cnt = c;
      v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ov = ov; v.uf = uf;
      return v;
   endfunction

   vec_t tbl [22];

   initial begin
      logic [DW-1:0] q [$];
      logic [DW-1:0] exp_dout;

      //              w r din       dout     cnt f e af ae ov uf
      tbl[0]  = mk(1, 0, 18'h00001, 18'h0,     1, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(1, 0, 18'h00002, 18'h0,     2, 0, 0, 0, 1, 0, 0);
      tbl[2]  = mk(1, 0, 18'h00003, 18'h0,     3, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 18'h00004, 18'h0,     4, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 18'h00005, 18'h0,     5, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 18'h00006, 18'h0,     6, 0, 0, 1, 0, 0, 0);
      tbl[6]  = mk(1, 0, 18'h00007, 18'h0,     7, 0, 0, 1, 0, 0, 0);
      tbl[7]  = mk(1, 0, 18'h00008, 18'h0,     8, 1, 0, 1, 0, 0, 0);
      tbl[8]  = mk(1, 0, 18'h00009, 18'h0,     8, 1, 0, 1, 0, 1, 0);
      tbl[9]  = mk(0, 0, 18'h0,     18'h0,     8, 1, 0, 1, 0, 0, 0);
      tbl[10] = mk(1, 1, 18'h3FFFF, 18'h00001, 8, 1, 0, 1, 0, 0, 0);
      tbl[11] = mk(0, 1, 18'h0,     18'h00002, 7, 0, 0, 1, 0, 0, 0);
      tbl[12] = mk(0, 1, 18'h0,     18'h00003, 6, 0, 0, 1, 0, 0, 0);
      tbl[13] = mk(0, 1, 18'h0,     18'h00004, 5, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 1, 18'h0,     18'h00005, 4, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 1, 18'h0,     18'h00006, 3, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 1, 18'h0,     18'h00007, 2, 0, 0, 0, 1, 0, 0);
      tbl[17] = mk(0, 1, 18'h0,     18'h00008, 1, 0, 0, 0, 1, 0, 0);
      tbl[18] = mk(0, 1, 18'h0,     18'h3FFFF, 0, 0, 1, 0, 1, 0, 0);
      tbl[19] = mk(0, 1, 18'h0,     18'h3FFFF, 0, 0, 1, 0, 1, 0, 1);
      tbl[20] = mk(1, 1, 18'h00055, 18'h3FFFF, 1, 0, 0, 0, 1, 0, 1);
      tbl[21] = mk(0, 1, 18'h0,     18'h00055, 0, 0, 1, 0, 1, 0, 0);

      bus.w_en = 1'b0; bus.r_en = 1'b0; bus.data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.dout", 32'(bus.data_out), 32'h0);
      chk("rst.ov",   32'(bus.overflow), 32'h0);
      chk("rst.uf",   32'(bus.underflow), 32'h0);
      chk_flags("rst", 0);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].din);
`ifndef FIFO_FWFT_EN
         chk($sformatf("v%0d.dout", i), 32'(bus.data_out), 32'(tbl[i].dout));
`endif
         chk($sformatf("v%0d.count", i), 32'(bus.count),        32'(tbl[i].cnt));
         chk($sformatf("v%0d.full", i),  32'(bus.full),         32'(tbl[i].full));
         chk($sformatf("v%0d.empty", i), 32'(bus.empty),        32'(tbl[i].empty));
         chk($sformatf("v%0d.af", i),    32'(bus.almost_full),  32'(tbl[i].af));
         chk($sformatf("v%0d.ae", i),    32'(bus.almost_empty), 32'(tbl[i].ae));
         chk($sformatf("v%0d.ov", i),    32'(bus.overflow),     32'(tbl[i].ov));
         chk($sformatf("v%0d.uf", i),    32'(bus.underflow),    32'(tbl[i].uf));
      end

      // Interleaved stream long enough to wrap both pointers several times.
      exp_dout = 18'h00055;
      for (int i = 0; i < 60; i++) begin
         logic w, r, rd, wr;
         logic [DW-1:0] d;
         w  = (i < 30) ? (i % 3 != 2) : (i % 4 == 0);
         r  = (i < 30) ? (i % 2 == 1) : 1'b1;
         d  = DW'($urandom_range(0, 32'h3FFFF));
         rd = r && (q.size() != 0);
         wr = w && (q.size() < DP || rd);
         step(w, r, d);
         if (rd) exp_dout = q.pop_front();
         if (wr) q.push_back(d);
`ifdef FIFO_FWFT_EN
         exp_dout = (q.size() != 0) ? q[0] : '0;
`endif
         chk($sformatf("s%0d.dout", i), 32'(bus.data_out),  32'(exp_dout));
         chk($sformatf("s%0d.ov", i),   32'(bus.overflow),  32'(w && !wr));
         chk($sformatf("s%0d.uf", i),   32'(bus.underflow), 32'(r && !rd));
         chk_flags($sformatf("s%0d", i), q.size());
      end

      // Asynchronous reset in the middle of a cycle with five words stored.
      bus.w_en = 1'b0; bus.r_en = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'h100 + i));
      chk_flags("pre_arst", 5);
      bus.w_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst.dout", 32'(bus.data_out), 32'h0);
      chk_flags("arst", 0);
      #1 rst = 1'b0;
      step(1'b1, 1'b0, 18'h00123);
      chk_flags("arst_w", 1);
`ifdef FIFO_FWFT_EN
      chk("arst_w.dout", 32'(bus.data_out), 32'h123);
`endif
      step(1'b0, 1'b1, 18'h0);
      chk_flags("arst_r", 0);
`ifdef FIFO_FWFT_EN
      chk("arst_r.dout", 32'(bus.data_out), 32'h0);
`else
      chk("arst_r.dout", 32'(bus.data_out), 32'h123);
`endif

`ifdef FIFO_FWFT_EN
      step(1'b1, 1'b0, 18'h00011);
      chk("fwft.dout", 32'(bus.data_out), 32'h11);
      chk_flags("fwft", 1);
      step(1'b0, 1'b1, 18'h0);
      chk("fwft_pop.dout", 32'(bus.data_out), 32'h0);
      chk_flags("fwft_pop", 0);
`endif

      step(1'b0, 1'b0, 18'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
